// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - start/stop framed MSB-first serial transmitter with mid-bit strobe
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   tx_data     parallel word, registered on the accept edge
//   tx_valid    producer offers tx_data
//   tx_ready    high only in IDLE (combinational)
//   sd_out      serial line, idles high (registered)
//   sd_strobe   one-cycle pulse at the centre of each data bit (registered)
//   busy        frame in progress (registered)
//   frame_done  one-cycle pulse on the last stop-bit cycle (registered)

module serial_frame_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sd_out,
  output logic              sd_strobe,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CYC_MID  = CW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sd_out_q, sd_out_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      sd_out_q <= 1'b1;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sd_out_q <= sd_out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = START;
          cyc_d   = '0;
          bit_d   = '0;
          shift_d = tx_data;
        end
      end
      START: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q << 1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with state_q in the same cycle.
  always_comb begin
    sd_out_d = 1'b1;
    case (state_d)
      START:   sd_out_d = 1'b0;
      DATA:    sd_out_d = shift_d[DATA_W-1];
      default: sd_out_d = 1'b1;
    endcase
    strobe_d = (state_d == DATA) && (cyc_d == CYC_MID);
    done_d   = (state_d == STOP) && (cyc_d == CYC_LAST);
    busy_d   = (state_d != IDLE);
  end

  assign tx_ready   = (state_q == IDLE);
  assign sd_out     = sd_out_q;
  assign sd_strobe  = strobe_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx

module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, sd_out, sd_strobe, busy, frame_done;

  logic [0:0] c_data = 1'b0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_sd, c_strobe, c_busy, c_done;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sd_out(sd_out), .sd_strobe(sd_strobe),
    .busy(busy), .frame_done(frame_done)
  );

  serial_frame_tx #(.DATA_W(1), .CLK_DIV(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .tx_data(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .sd_out(c_sd), .sd_strobe(c_strobe),
    .busy(c_busy), .frame_done(c_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe-enabled latch reassembles the word; compared on frame_done.
  logic [7:0] rx = 8'h00;
  int nbits = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      rx = 8'h00;
      nbits = 0;
    end else begin
      if (sd_strobe) begin
        rx = {rx[6:0], sd_out};
        nbits++;
      end
      if (frame_done) begin
        check("strobe_count", 64'(nbits), 64'd8);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'(rx), 64'hFFFF);
        end else begin
          check("loopback_word", 64'(rx), 64'(exp_q.pop_front()));
        end
        nbits = 0;
      end
    end
  end

  task automatic send(input logic [7:0] w, input bit push);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = w;
    if (push) exp_q.push_back(w);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    repeat (40) @(negedge clk);
  endtask

  logic [40:0] v_sd, v_st, v_dn, v_rd, v_bz;
  logic [6:0]  c_sd_v, c_st_v, c_dn_v, c_rd_v;
  bit          line_ok, strobe_none;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sd_out", 64'(sd_out), 64'd1);
    check("rst_tx_ready", 64'(tx_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobe", 64'(sd_strobe), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    reset_n = 1'b1;
    line_ok = 1'b1;
    strobe_none = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (sd_out !== 1'b1) line_ok = 1'b0;
      if (sd_strobe !== 1'b0) strobe_none = 1'b0;
    end
    check("idle_line_high", 64'(line_ok), 64'd1);
    check("idle_no_strobe", 64'(strobe_none), 64'd1);

    // Single 0xA5 frame, per-cycle trace for cycles 1..41
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tx_valid = 1'b0;
        tx_data  = 8'h3C;
      end
      v_sd[41-c] = sd_out;
      v_st[41-c] = sd_strobe;
      v_dn[41-c] = frame_done;
      v_rd[41-c] = tx_ready;
      v_bz[41-c] = busy;
    end
    check("a5_line", 64'(v_sd), 64'({4'h0, 32'hF0F00F0F, 4'hF, 1'b1}));
    check("a5_strobe", 64'(v_st), 64'({4'h0, 32'h22222222, 4'h0, 1'b0}));
    check("a5_done", 64'(v_dn), 64'(41'b10));
    check("a5_ready", 64'(v_rd), 64'(41'b1));
    check("a5_busy", 64'(v_bz), 64'({{40{1'b1}}, 1'b0}));

    // Parameter corner: DATA_W=1, CLK_DIV=2, send 1
    @(negedge clk);
    c_valid = 1'b1;
    c_data  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        c_valid = 1'b0;
        c_data  = 1'b0;
      end
      c_sd_v[7-c] = c_sd;
      c_st_v[7-c] = c_strobe;
      c_dn_v[7-c] = c_done;
      c_rd_v[7-c] = c_ready;
    end
    check("corner_line", 64'(c_sd_v), 64'(7'b0011111));
    check("corner_strobe", 64'(c_st_v), 64'(7'b0001000));
    check("corner_done", 64'(c_dn_v), 64'(7'b0000010));
    check("corner_ready", 64'(c_rd_v), 64'(7'b0000001));

    // Directed and random loopback
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h5A, 1'b1);
    for (int i = 0; i < 200; i++) send(8'($urandom), 1'b1);

    // Hold-off: valid held high, word changes every cycle
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'(11);
    exp_q.push_back(8'(11));
    exp_q.push_back(8'(41 * 37 + 11));
    exp_q.push_back(8'(82 * 37 + 11));
    for (int j = 1; j <= 82; j++) begin
      @(negedge clk);
      tx_data = 8'(j * 37 + 11);
      if (j == 40) check("gap1_busy", 64'(tx_ready), 64'd0);
      if (j == 41) check("gap1_ready", 64'(tx_ready), 64'd1);
      if (j == 81) check("gap2_busy", 64'(tx_ready), 64'd0);
      if (j == 82) check("gap2_ready", 64'(tx_ready), 64'd1);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (41) @(negedge clk);

    // Reset mid-frame during data bit 3 of 0xC3
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("c3_bit3_line", 64'(sd_out), 64'd0);
    reset_n = 1'b0;
    #1;
    check("abort_line", 64'(sd_out), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(tx_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(8'h3C, 1'b1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmit end of the team's single-wire serial data link.
- Accepts a parallel word on a valid/ready handshake and serialises it MSB-first inside a start/stop frame.
- Emits a one-cycle mid-bit strobe so the receiving end can capture each data bit with a level-sensitive D latch (latch enable = strobe).
- Sits between a parallel producer and the serial line driver.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLK_DIV, 4, clk cycles per serial bit (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
tx_data  input  DATA_W  parallel word to send
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  block can accept a word this cycle
sd_out  output  1  serial line, idles high
sd_strobe  output  1  one-cycle pulse at the centre of each data bit
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, sd_out=1, tx_ready=1, sd_strobe=0, busy=0, frame_done=0; shift register and counters cleared.
  - Reset applies immediately, with no clock edge required.
  - Reset mid-frame aborts the frame, discards the word and returns the line high at once.
  - First accept is possible on the first clk edge after reset_n deasserts.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is registered on that edge.
  - Later changes to tx_data have no effect on the frame.
  - tx_valid while tx_ready=0 is ignored; there is no queue, so the producer must hold.
  - tx_ready is combinationally 1 only in IDLE.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on transfer.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> STOP after DATA_W*CLK_DIV cycles.
  - STOP -> IDLE after CLK_DIV cycles.
- Line levels: IDLE sd_out=1; START sd_out=0; DATA sd_out=current MSB of the shift register, shifting left one place every CLK_DIV cycles; STOP sd_out=1.
- Counters:
  - Bit-cycle counter runs 0..CLK_DIV-1 and wraps at each bit boundary.
  - Bit index runs 0..DATA_W-1 in DATA.
  - Both reset to 0 on entry to START.
- sd_strobe=1 in DATA only, on the cycle where the bit-cycle counter = CLK_DIV/2 (floor). Exactly DATA_W strobes per frame.
- frame_done=1 on the final STOP cycle (bit-cycle counter = CLK_DIV-1).
- busy=1 in START, DATA and STOP.
- Timing: with the accept edge as cycle 0, a frame occupies cycles 1..(DATA_W+2)*CLK_DIV. tx_ready returns high the following cycle.
  - Minimum one IDLE cycle between frames, so back-to-back valid sees a single-cycle gap.
- All outputs are registered except tx_ready. No combinational path from tx_data to sd_out.
- tx_data=all-zeros and all-ones are legal and require no special case.

Test Plan:
- Reset values: hold reset_n=0 for 3 cycles -> sd_out=1, tx_ready=1, busy=0, sd_strobe=0, frame_done=0. Deassert and stay idle 10 cycles -> line stays 1, no strobes.
- Single frame, DATA_W=8, CLK_DIV=4, send 0xA5, accept at cycle 0:
  - sd_out=0 in cycles 1-4.
  - Data bits 1,0,1,0,0,1,0,1 follow, each for 4 cycles, over cycles 5-36.
  - sd_out=1 in cycles 37-40.
  - sd_strobe high exactly at cycles 7,11,...,35 (8 pulses).
  - frame_done at cycle 40; tx_ready=1 at cycle 41.
- Loopback: sample sd_out with a D latch enabled by sd_strobe, shifting the captured bits in, for 0x00, 0xFF, 0x5A and 200 random words -> reassembled word equals the sent word every time.
- Hold-off: tx_valid held high continuously with a word changed every cycle -> one accept per frame, each frame carries the word present on its accept edge, and the idle gap between frames is exactly 1 cycle.
- Reset mid-frame: assert reset_n=0 during data bit 3 of 0xC3 -> sd_out=1 and busy=0 with no clock edge. After release, a new word 0x3C transmits correctly with no residue from 0xC3.
- Parameter corner: DATA_W=1, CLK_DIV=2, send 1 -> frame is 6 cycles (0,0,1,1,1,1), one strobe at cycle 4, frame_done at cycle 6.
